// File: rtl/target_defs_pkg.sv
// Shared definitions for the target game: FSM encodings, length limits, lane width.
package target_defs_pkg;

   localparam int unsigned LANE_W = 4;
   localparam int unsigned LEN_W  = 3;

   localparam logic [LEN_W-1:0] MAX_LEN = 3'd4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Length codes above MAX_LEN behave as MAX_LEN
   function automatic logic [LEN_W-1:0] clamp_len(input logic [31:0] code);
      return (code > 32'(MAX_LEN)) ? MAX_LEN : LEN_W'(code);
   endfunction

   // 32-bit add that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/target_slot.sv
// One target lane: holds liveness, remaining lifetime and the stored length code.
module target_slot
   import target_defs_pkg::*;
#(
   parameter int unsigned LIFE_W = 27
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [LIFE_W-1:0] lifetime,
   input  logic [LEN_W-1:0]  len_in,
   input  logic              kill,
   output logic              live,
   output logic              expire_pulse,
   output logic [LEN_W-1:0]  len
);

   logic [LIFE_W-1:0] remain;

   // Last live cycle of the slot; the clear happens on the following edge
   assign expire_pulse = live && (remain == LIFE_W'(1));

   // Lifetime countdown; kill and expiry clear, load only into a dead slot
   always_ff @(posedge clk) begin
      if (reset) begin
         live   <= 1'b0;
         remain <= '0;
         len    <= '0;
      end else if (kill || expire_pulse) begin
         live   <= 1'b0;
         remain <= '0;
      end else if (load && !live) begin
         live   <= 1'b1;
         remain <= lifetime;
         len    <= len_in;
      end else if (live) begin
         remain <= remain - LIFE_W'(1);
      end
   end

endmodule

// File: rtl/target_scheduler.sv
// Target scheduler: periodic spawns into lanes, hit/expiry scoring, game FSM.
module target_scheduler
   import target_defs_pkg::*;
#(
   parameter int unsigned NUM_TARGETS    = 10,
   parameter int unsigned SPAWN_INTERVAL = 50000000,
   parameter int unsigned LIFE_UNIT      = 25000000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            ranNumTen,
   input  logic [31:0]            ranNumLength,
   input  logic                   game_active,
   input  logic                   hit_valid,
   input  logic [LANE_W-1:0]      hit_target,
   output logic [NUM_TARGETS-1:0] target_valid,
   output logic                   spawn_pulse,
   output logic [31:0]            score,
   output logic [31:0]            miss_count,
   output logic                   busy
);

   localparam int unsigned CNT_W    = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
   localparam int unsigned LIFE_MAX = (32'(MAX_LEN) + 1) * LIFE_UNIT;
   localparam int unsigned LIFE_W   = $clog2(LIFE_MAX + 1);

   logic [1:0]             state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   attempt;
   logic                   hit_act;
   logic                   hit_miss;
   logic                   spawn_ok;
   logic [LEN_W-1:0]       len_c;
   logic [LEN_W-1:0]       hit_len;
   logic [LIFE_W-1:0]      lifetime_c;
   logic [NUM_TARGETS-1:0] live_vec, exp_vec, hit_vec, load_vec;
   logic [LEN_W-1:0]       len_arr [NUM_TARGETS];
   logic [31:0]            miss_inc;
   logic [31:0]            score_nxt, miss_nxt;

   // Lane slots
   for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_slot
      target_slot #(.LIFE_W(LIFE_W)) u_slot (
         .clk          (clk),
         .reset        (reset),
         .load         (load_vec[g]),
         .lifetime     (lifetime_c),
         .len_in       (len_c),
         .kill         (hit_vec[g]),
         .live         (live_vec[g]),
         .expire_pulse (exp_vec[g]),
         .len          (len_arr[g])
      );
   end

   assign target_valid = live_vec;

   // Next state, interval counter, hit/spawn decode and counter updates
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      hit_vec    = '0;
      hit_len    = '0;
      load_vec   = '0;
      miss_inc   = '0;
      score_nxt  = score;
      miss_nxt   = miss_count;
      len_c      = clamp_len(ranNumLength);
      lifetime_c = LIFE_W'((32'(len_c) + 32'd1) * LIFE_UNIT);
      attempt    = (state == ST_RUN) && (cnt == CNT_W'(SPAWN_INTERVAL - 1));
      hit_act    = hit_valid && (state != ST_IDLE);

      // Hits are judged against the slot state before this edge
      for (int i = 0; i < NUM_TARGETS; i++) begin
         if (hit_act && (hit_target == LANE_W'(i)) && live_vec[i]) begin
            hit_vec[i] = 1'b1;
            hit_len    = len_arr[i];
         end
      end
      hit_miss = hit_act && (hit_vec == '0);

      // A spawn lands only on a dead lane that is not being hit this cycle
      for (int i = 0; i < NUM_TARGETS; i++) begin
         if (attempt && (ranNumTen == 32'(i)) && !live_vec[i] &&
             !(hit_act && (hit_target == LANE_W'(i)))) begin
            load_vec[i] = 1'b1;
         end
      end
      spawn_ok = |load_vec;

      // Expiries lose to a hit on the same lane
      for (int i = 0; i < NUM_TARGETS; i++) begin
         miss_inc = miss_inc + 32'(exp_vec[i] & ~hit_vec[i]);
      end
      miss_inc = miss_inc + 32'(hit_miss);

      case (state)
         ST_IDLE: begin
            if (game_active) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
               score_nxt = '0;
               miss_nxt  = '0;
            end
         end
         ST_RUN: begin
            cnt_nxt = attempt ? '0 : cnt + CNT_W'(1);
            if (!game_active) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (game_active)           state_nxt = ST_RUN;
            else if (live_vec == '0)   state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (state != ST_IDLE) begin
         if (hit_vec != '0) score_nxt = sat_add(score, 32'(hit_len) + 32'd1);
         miss_nxt = sat_add(miss_count, miss_inc);
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         spawn_pulse <= 1'b0;
         score       <= '0;
         miss_count  <= '0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         spawn_pulse <= spawn_ok;
         score       <= score_nxt;
         miss_count  <= miss_nxt;
         busy        <= (state_nxt != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_target_scheduler.sv
// Directed bench for target_scheduler with small timing parameters.
module tb_target_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ranNumTen;
   logic [31:0] ranNumLength;
   logic        game_active;
   logic        hit_valid;
   logic [3:0]  hit_target;
   logic [9:0]  target_valid;
   logic        spawn_pulse;
   logic [31:0] score;
   logic [31:0] miss_count;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   target_scheduler #(
      .NUM_TARGETS    (10),
      .SPAWN_INTERVAL (8),
      .LIFE_UNIT      (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ranNumTen    (ranNumTen),
      .ranNumLength (ranNumLength),
      .game_active  (game_active),
      .hit_valid    (hit_valid),
      .hit_target   (hit_target),
      .target_valid (target_valid),
      .spawn_pulse  (spawn_pulse),
      .score        (score),
      .miss_count   (miss_count),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reset, then raise game_active; returns just after edge E7 (cycle 7)
   task automatic start_game(input logic [31:0] ten, input logic [31:0] len);
      reset       = 1'b1;
      game_active = 1'b0;
      hit_valid   = 1'b0;
      hit_target  = 4'd0;
      tick();
      tick();
      reset        = 1'b0;
      ranNumTen    = ten;
      ranNumLength = len;
      game_active  = 1'b1;
      tick();               // E0: enter RUN
      repeat (7) tick();    // E1..E7
   endtask

   initial begin
      reset        = 1'b1;
      ranNumTen    = 32'd12;
      ranNumLength = 32'd0;
      game_active  = 1'b0;
      hit_valid    = 1'b0;
      hit_target   = 4'd0;
      tick();
      tick();
      check("rst_valid", 32'(target_valid), 32'h0);
      check("rst_pulse", 32'(spawn_pulse), 32'h0);
      check("rst_score", score, 32'h0);
      check("rst_miss",  miss_count, 32'h0);
      check("rst_busy",  32'(busy), 32'h0);

      // Lane 3, L=1: live cycles 8..15, expiry miss at 16
      start_game(32'd3, 32'd1);
      check("s1_c7_pulse", 32'(spawn_pulse), 32'h0);
      check("s1_c7_valid", 32'(target_valid), 32'h0);
      check("s1_c7_busy",  32'(busy), 32'h1);
      tick();
      check("s1_c8_pulse", 32'(spawn_pulse), 32'h1);
      check("s1_c8_valid", 32'(target_valid), 32'h008);
      ranNumTen = 32'd12;
      tick();
      check("s1_c9_pulse", 32'(spawn_pulse), 32'h0);
      repeat (6) tick();
      check("s1_c15_valid", 32'(target_valid), 32'h008);
      check("s1_c15_miss",  miss_count, 32'h0);
      tick();
      check("s1_c16_valid", 32'(target_valid), 32'h0);
      check("s1_c16_miss",  miss_count, 32'h1);
      check("s1_c16_pulse", 32'(spawn_pulse), 32'h0);

      // Same spawn, hit lane 3 in cycle 10
      start_game(32'd3, 32'd1);
      tick();
      ranNumTen = 32'd12;
      tick();
      tick();
      hit_valid  = 1'b1;
      hit_target = 4'd3;
      tick();
      hit_valid = 1'b0;
      check("s2_c11_valid", 32'(target_valid), 32'h0);
      check("s2_c11_score", score, 32'd2);
      check("s2_c11_miss",  miss_count, 32'h0);
      repeat (5) tick();
      check("s2_c16_miss", miss_count, 32'h0);

      // Out-of-range lane discarded; length code 7 clamps to 4 (20 cycles)
      start_game(32'd12, 32'd0);
      tick();
      check("s3_c8_pulse", 32'(spawn_pulse), 32'h0);
      check("s3_c8_valid", 32'(target_valid), 32'h0);
      ranNumTen    = 32'd0;
      ranNumLength = 32'd7;
      repeat (8) tick();
      check("s3_c16_pulse", 32'(spawn_pulse), 32'h1);
      check("s3_c16_valid", 32'(target_valid), 32'h001);
      ranNumTen = 32'd12;
      repeat (19) tick();
      check("s3_c35_valid", 32'(target_valid), 32'h001);
      // Expiry plus a wrong-lane hit in the same cycle
      hit_valid  = 1'b1;
      hit_target = 4'd7;
      tick();
      hit_valid = 1'b0;
      check("s3_c36_valid", 32'(target_valid), 32'h0);
      check("s3_c36_miss",  miss_count, 32'd2);

      // Lane 5, L=0: hit in its expiry cycle, then dead-lane hits
      start_game(32'd5, 32'd0);
      tick();
      check("s4_c8_valid", 32'(target_valid), 32'h020);
      ranNumTen = 32'd12;
      repeat (3) tick();
      hit_valid  = 1'b1;
      hit_target = 4'd5;
      tick();
      check("s4_c12_valid", 32'(target_valid), 32'h0);
      check("s4_c12_score", score, 32'd1);
      check("s4_c12_miss",  miss_count, 32'h0);
      hit_target = 4'd6;
      tick();
      check("s4_dead_miss", miss_count, 32'd1);
      hit_target = 4'd15;
      tick();
      hit_valid = 1'b0;
      check("s4_range_miss", miss_count, 32'd2);
      check("s4_score_hold", score, 32'd1);

      // Drain: game stops with lane 2 live
      start_game(32'd2, 32'd0);
      tick();
      check("s5_c8_valid", 32'(target_valid), 32'h004);
      game_active = 1'b0;
      tick();
      check("s5_c9_busy", 32'(busy), 32'h1);
      repeat (2) tick();
      check("s5_c11_valid", 32'(target_valid), 32'h004);
      check("s5_c11_busy",  32'(busy), 32'h1);
      tick();
      check("s5_c12_valid", 32'(target_valid), 32'h0);
      check("s5_c12_busy",  32'(busy), 32'h1);
      check("s5_c12_miss",  miss_count, 32'd1);
      tick();
      check("s5_c13_busy", 32'(busy), 32'h0);
      repeat (10) tick();
      check("s5_idle_valid", 32'(target_valid), 32'h0);
      check("s5_idle_pulse", 32'(spawn_pulse), 32'h0);
      check("s5_idle_miss",  miss_count, 32'd1);

      // Reset mid-run with three live lanes
      start_game(32'd1, 32'd4);
      tick();
      ranNumTen = 32'd4;
      repeat (8) tick();
      ranNumTen = 32'd7;
      repeat (8) tick();
      check("s6_c24_valid", 32'(target_valid), 32'h092);
      check("s6_c24_pulse", 32'(spawn_pulse), 32'h1);
      reset = 1'b1;
      tick();
      check("s6_rst_valid", 32'(target_valid), 32'h0);
      check("s6_rst_pulse", 32'(spawn_pulse), 32'h0);
      check("s6_rst_score", score, 32'h0);
      check("s6_rst_miss",  miss_count, 32'h0);
      check("s6_rst_busy",  32'(busy), 32'h0);
      reset       = 1'b0;
      game_active = 1'b0;
      tick();

      // Score saturation, then hit and spawn on the same dead lane
      start_game(32'd0, 32'd4);
      tick();
      check("s7_c8_valid", 32'(target_valid), 32'h001);
      ranNumTen = 32'd12;
      tick();
      force dut.score = 32'hFFFF_FFFE;
      #1;
      release dut.score;
      hit_valid  = 1'b1;
      hit_target = 4'd0;
      tick();
      hit_valid = 1'b0;
      check("s7_sat_score", score, 32'hFFFF_FFFF);
      check("s7_sat_valid", 32'(target_valid), 32'h0);
      repeat (5) tick();
      ranNumTen    = 32'd3;
      ranNumLength = 32'd0;
      hit_valid    = 1'b1;
      hit_target   = 4'd3;
      tick();
      hit_valid = 1'b0;
      check("s7_c16_pulse", 32'(spawn_pulse), 32'h0);
      check("s7_c16_valid", 32'(target_valid), 32'h0);
      check("s7_c16_miss",  miss_count, 32'd1);
      check("s7_c16_score", score, 32'hFFFF_FFFF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/target_scheduler.md
TARGET_SCHEDULER -- requirements
Module: target_scheduler

Interface
REQ-001 Parameter NUM_TARGETS, default 10, number of target lanes, one slot per lane.
REQ-002 Parameter SPAWN_INTERVAL, default 50000000, clk cycles between spawn attempts.
REQ-003 Parameter LIFE_UNIT, default 25000000, clk cycles of target lifetime per length unit.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ranNumTen  input  32  random lane index from the generator; only values 0..NUM_TARGETS-1 are legal.
REQ-007 ranNumLength  input  32  random length code from the generator; legal range 0..4.
REQ-008 game_active  input  1  level; high = game running.
REQ-009 hit_valid  input  1  one-cycle strobe; the player pressed a lane.
REQ-010 hit_target  input  4  lane pressed, qualified by hit_valid.
REQ-011 target_valid  output  NUM_TARGETS  bitmap, bit i high = lane i has a live target.
REQ-012 spawn_pulse  output  1  one-cycle strobe, a target was spawned this cycle.
REQ-013 score  output  32  accumulated points.
REQ-014 miss_count  output  32  accumulated misses.
REQ-015 busy  output  1  high in RUN or DRAIN.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DRAIN.
REQ-017 IDLE->RUN SHALL occur when game_active=1; on this transition score, miss_count and the interval counter SHALL clear.
REQ-018 RUN->DRAIN SHALL occur when game_active=0.
REQ-019 DRAIN->IDLE SHALL occur when target_valid==0; DRAIN->RUN SHALL occur if game_active rises again, without clearing score.
REQ-020 In RUN the interval counter SHALL count 0..SPAWN_INTERVAL-1 and wrap; a spawn attempt SHALL occur in the cycle it equals SPAWN_INTERVAL-1, so the first attempt comes SPAWN_INTERVAL cycles after entering RUN.
REQ-021 The interval counter SHALL hold in IDLE and DRAIN; no spawn attempts SHALL occur in those states.
REQ-022 At an attempt, ranNumTen and ranNumLength SHALL be sampled in that cycle only.
REQ-023 ranNumTen >= NUM_TARGETS SHALL discard the attempt: no spawn, no pulse, no counter change.
REQ-024 The effective length L SHALL be ranNumLength when <=4, and 4 otherwise.
REQ-025 An attempt to an already-live lane SHALL be dropped: the existing lifetime is unchanged and no pulse is raised.
REQ-026 On a successful attempt, target_valid[lane] and spawn_pulse SHALL be high the following cycle, and the slot lifetime SHALL load (L+1)*LIFE_UNIT.
REQ-027 A live slot SHALL stay valid for exactly (L+1)*LIFE_UNIT cycles.
REQ-028 At expiry of a live slot, the slot SHALL clear and miss_count SHALL increment by 1.
REQ-029 A hit_valid on a live lane SHALL clear it the next cycle and add L+1 to score.
REQ-030 A hit_valid on a dead lane or a lane >= NUM_TARGETS SHALL increment miss_count.
REQ-031 Hits SHALL be processed in RUN and DRAIN and ignored in IDLE.
REQ-032 Hit and expiry on the same lane in the same cycle: the hit SHALL win (score, no miss).
REQ-033 Hit and spawn attempt on the same lane in the same cycle: the hit SHALL be evaluated on the old state, and the spawn SHALL be dropped.
REQ-034 If one cycle contains both a miss by expiry and a miss by wrong hit, miss_count SHALL increment by 2.
REQ-035 Simultaneous expiries SHALL each add 1 to miss_count.
REQ-036 score and miss_count SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-037 With reset high at a clk edge, the state SHALL be IDLE, all slots dead, the counters zero, and target_valid, spawn_pulse, score, miss_count and busy all 0.
REQ-038 Reset mid-game SHALL override all other events in that cycle; no score or miss SHALL be recorded for slots killed by reset.

Structure
REQ-039 The state encodings, the maximum length code (4) and the width of the lane index SHALL live in a shared target_defs package/header, shared with the generator and the display logic.
REQ-040 Each lane SHALL be one instance of the sub-module target_slot (inputs load, lifetime, kill; outputs live, expire_pulse, stored L), generated NUM_TARGETS times.

Verification
REQ-041 All scenarios use NUM_TARGETS=10, SPAWN_INTERVAL=8, LIFE_UNIT=4.
REQ-042 Reset, then game_active=1 at cycle 0 with ranNumTen=3, ranNumLength=1 -> spawn_pulse at cycle 8, target_valid=0x008 for cycles 8..15, clear at cycle 16, miss_count=1.
REQ-043 Same spawn, then hit_target=3 at cycle 10 -> target_valid=0 at cycle 11, score=2, miss_count=0.
REQ-044 ranNumTen=12 -> no spawn_pulse; ranNumLength=7 on lane 0 -> lane 0 live for 20 cycles.
REQ-045 Lane 5 live with L=0; hit on lane 5 in the expiry cycle -> score=1, miss_count=0; hit on dead lane 6 -> miss_count=1.
REQ-046 game_active drops with lane 2 live -> busy stays 1 through DRAIN, no further spawns, IDLE after expiry.
REQ-047 Reset asserted mid-RUN with 3 lanes live -> all outputs 0 next cycle.
REQ-048 Preload score at 32'hFFFFFFFE, then hit with L=4 -> score=32'hFFFFFFFF.
